// File: rtl/data_mem_periph_pkg.sv
// data_mem_periph_pkg
//   Shared constants for the data memory / peripheral block:
//   - peripheral register offsets relative to PERIPH_BASE
//   - TCON bit positions
//   - timer register select encoding used between the top and periph_timer
//   - helper that sizes the RAM word index from the RAM depth
package data_mem_periph_pkg;

  // Register offsets inside the peripheral window (word aligned)
  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_LED     = 32'h0000_000C;
  localparam logic [31:0] OFF_SWITCH  = 32'h0000_0010;
  localparam logic [31:0] OFF_DIGI    = 32'h0000_0014;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0018;

  // TCON bit positions: enable, interrupt enable, sticky interrupt status
  localparam int TCON_TEN = 0;
  localparam int TCON_IEN = 1;
  localparam int TCON_IST = 2;

  // Which timer register an access targets
  typedef enum logic [1:0] {
    TSEL_TH   = 2'd0,
    TSEL_TL   = 2'd1,
    TSEL_TCON = 2'd2,
    TSEL_NONE = 2'd3
  } timer_sel_e;

  // Number of index bits needed to address a RAM of 'words' entries
  // (at least one bit so a degenerate one-word RAM still elaborates)
  function automatic int ram_idx_w(input int words);
    int w;
    w = $clog2(words);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_periph_timer.sv
// periph_timer
//   Reload timer with TH (reload value), TL (counter) and TCON
//   (enable / interrupt enable / sticky status) plus a registered irq.
//   When enabled TL counts up; on reaching all ones it reloads from TH and,
//   if interrupts are enabled, latches the status bit.
// Ports:
//   clk      in   system clock
//   reset_b  in   asynchronous active-low reset
//   wr_en    in   write strobe for the selected register
//   sel      in   register select (timer_sel_e encoding)
//   wr_data  in   write data
//   rd_data  out  selected register value, combinational, zero otherwise
//   irq      out  interrupt request, driven straight from a flop
module periph_timer
  import data_mem_periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        wr_en,
  input  logic [1:0]  sel,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [2:0]  tcon_next;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        reload;

  assign wr_th   = wr_en && (sel == TSEL_TH);
  assign wr_tl   = wr_en && (sel == TSEL_TL);
  assign wr_tcon = wr_en && (sel == TSEL_TCON);
  assign reload  = tcon[TCON_TEN] && (tl == 32'hFFFF_FFFF);

  // Next TCON: software write first, then a hardware status set on top so an
  // interrupt arriving in the same cycle as a status clear is never lost.
  always_comb begin
    tcon_next = tcon;
    if (wr_tcon) tcon_next = wr_data[2:0];
    if (reload && tcon[TCON_IEN]) tcon_next[TCON_IST] = 1'b1;
  end

  // Timer state. A software TL write beats the increment/reload; a reload
  // always uses the TH value from before any same-cycle TH write.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_th) th <= wr_data;
      if (wr_tl) tl <= wr_data;
      else if (tcon[TCON_TEN]) tl <= reload ? th : tl + 32'd1;
      tcon <= tcon_next;
      irq  <= tcon_next[TCON_IEN] & tcon_next[TCON_IST];
    end
  end

  // Read mux
  always_comb begin
    rd_data = '0;
    case (sel)
      TSEL_TH:   rd_data = th;
      TSEL_TL:   rd_data = tl;
      TSEL_TCON: rd_data = {29'b0, tcon};
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_periph.sv
// data_mem_periph
//   Data memory stage slave: word-addressed data RAM plus a peripheral
//   window (reload timer, LED register, synchronized switches, 7-segment
//   register). Loads return combinationally in the same cycle.
//   Optional feature macro SYSTICK_EN: adds a read-only free-running cycle
//   counter at PERIPH_BASE+0x18; without it that offset reads 0.
// Ports:
//   clk        in   system clock
//   reset_b    in   asynchronous active-low reset (RAM is not reset)
//   MemRead    in   load request
//   MemWrite   in   store request
//   Address    in   byte address, low two bits ignored
//   WriteData  in   store data
//   ReadData   out  load data, combinational, 0 when MemRead is low
//   switch     in   board switches (asynchronous)
//   led        out  LED register
//   digi       out  7-segment register {anode[3:0], segment[7:0]}
//   irq        out  timer interrupt request (level)
module data_mem_periph
  import data_mem_periph_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
)
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);

  localparam int          IDX_W     = ram_idx_w(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      ram [RAM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      word_addr;
  logic [31:0]      off;
  logic             ram_hit;
  logic             hit_th;
  logic             hit_tl;
  logic             hit_tcon;
  logic             hit_led;
  logic             hit_switch;
  logic             hit_digi;
  logic             timer_hit;
  logic [1:0]       timer_sel;
  logic [31:0]      timer_rd;
  logic [7:0]       switch_meta;
  logic [7:0]       switch_sync;
  logic [31:0]      rd_val;
  logic             addr_unused;

  // Byte lanes are not supported, so the two low address bits carry no meaning
  assign addr_unused = &Address[1:0];

  // Address decode. RAM takes priority; peripheral registers are matched by
  // their exact word offset from the window base.
  assign word_addr  = {Address[31:2], 2'b00};
  assign off        = word_addr - PERIPH_BASE;
  assign ram_hit    = word_addr < RAM_BYTES;
  assign ram_idx    = Address[IDX_W+1:2];
  assign hit_th     = !ram_hit && (off == OFF_TH);
  assign hit_tl     = !ram_hit && (off == OFF_TL);
  assign hit_tcon   = !ram_hit && (off == OFF_TCON);
  assign hit_led    = !ram_hit && (off == OFF_LED);
  assign hit_switch = !ram_hit && (off == OFF_SWITCH);
  assign hit_digi   = !ram_hit && (off == OFF_DIGI);
  assign timer_hit  = hit_th | hit_tl | hit_tcon;

  // Timer register select for the sub-module
  always_comb begin
    timer_sel = TSEL_NONE;
    if (hit_th)   timer_sel = TSEL_TH;
    if (hit_tl)   timer_sel = TSEL_TL;
    if (hit_tcon) timer_sel = TSEL_TCON;
  end

  periph_timer u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .wr_en   (MemWrite && timer_hit),
    .sel     (timer_sel),
    .wr_data (WriteData),
    .rd_data (timer_rd),
    .irq     (irq)
  );

  // Data RAM: contents survive reset, so no reset branch here
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) ram[ram_idx] <= WriteData;
  end

  // LED / 7-segment registers and the two-flop switch synchronizer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      led         <= '0;
      digi        <= '0;
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      if (MemWrite && hit_led)  led  <= WriteData[7:0];
      if (MemWrite && hit_digi) digi <= WriteData[11:0];
      switch_meta <= switch;
      switch_sync <= switch_meta;
    end
  end

`ifdef SYSTICK_EN
  logic [31:0] systick;
  logic        hit_systick;

  assign hit_systick = !ram_hit && (off == OFF_SYSTICK);

  // Free-running cycle counter; software cannot write it
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) systick <= '0;
    else          systick <= systick + 32'd1;
  end
`endif

  // Read mux; hits are mutually exclusive so plain ifs are enough.
  // This sees pre-write state, which gives read-before-write on a
  // combined read/write cycle.
  always_comb begin
    rd_val = '0;
    if (ram_hit)    rd_val = ram[ram_idx];
    if (timer_hit)  rd_val = timer_rd;
    if (hit_led)    rd_val = {24'b0, led};
    if (hit_switch) rd_val = {24'b0, switch_sync};
    if (hit_digi)   rd_val = {20'b0, digi};
`ifdef SYSTICK_EN
    if (hit_systick) rd_val = systick;
`endif
  end

  assign ReadData = MemRead ? rd_val : 32'h0;

endmodule

// File: tb/tb_data_mem_periph.sv
// tb_data_mem_periph
//   Directed self-checking bench for data_mem_periph: RAM access and decode,
//   timer reload/interrupt and same-cycle races, switch/LED/digi registers,
//   and asynchronous reset in the middle of counting.
module tb_data_mem_periph;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_SYS  = 32'h4000_0018;
  localparam logic [31:0] A_BAD  = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int errors = 0;
  int checks = 0;

  data_mem_periph dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .switch    (switch),
    .led       (led),
    .digi      (digi),
    .irq       (irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Store: drive the bus, let one rising edge take it, return 1ns later
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  // Load: combinational, sampled 1ns after driving, no clock edge consumed
  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
  endtask

  // Reset values while reset is held and just after release
  task automatic test_reset();
    logic [31:0] rd;
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (led !== 8'h00) begin errors++; $display("[TB] FAIL reset_led: got %h expected 00", led); end
    checks++; if (digi !== 12'h000) begin errors++; $display("[TB] FAIL reset_digi: got %h expected 000", digi); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    do_read(A_TH, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_th: got %h expected 00000000", rd); end
    do_read(A_TL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_tl: got %h expected 00000000", rd); end
    do_read(A_TCON, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_tcon: got %h expected 00000000", rd); end
  endtask

  // RAM store/load, ignored low address bits, out-of-range and read gating
  task automatic test_ram();
    logic [31:0] rd;
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_read_10: got %h expected deadbeef", rd); end
    do_read(32'h0000_0013, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_read_13: got %h expected deadbeef", rd); end
    Address = 32'h0000_0010;
    MemRead = 1'b0;
    #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL ram_noread: got %h expected 00000000", ReadData); end
    do_write(32'h0000_0000, 32'h0000_0000);
    do_write(32'h0000_0400, 32'h1234_5678);
    do_read(32'h0000_0400, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ram_oob_read: got %h expected 00000000", rd); end
    do_read(32'h0000_0000, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ram_oob_alias: got %h expected 00000000", rd); end
    // Combined read and write: old value now, new value after the edge
    Address   = 32'h0000_0010;
    WriteData = 32'h1111_1111;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    #1;
    checks++; if (ReadData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_rw_old: got %h expected deadbeef", ReadData); end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    #1;
    checks++; if (ReadData !== 32'h1111_1111) begin errors++; $display("[TB] FAIL ram_rw_new: got %h expected 11111111", ReadData); end
    MemRead = 1'b0;
  endtask

  // Count to all ones, reload from TH, raise status and irq, then clear
  task automatic test_timer_reload();
    logic [31:0] rd;
    do_write(A_TH, 32'hFFFF_FFFC);
    do_write(A_TL, 32'hFFFF_FFFE);
    do_write(A_TCON, 32'h0000_0003);
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL tmr_tl0: got %h expected fffffffe", rd); end
    @(posedge clk);
    #1;
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL tmr_tl1: got %h expected ffffffff", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL tmr_irq_early: got %b expected 0", irq); end
    @(posedge clk);
    #1;
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL tmr_reload: got %h expected fffffffc", rd); end
    do_read(A_TCON, rd);
    checks++; if (rd !== 32'h0000_0007) begin errors++; $display("[TB] FAIL tmr_tcon_ist: got %h expected 00000007", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL tmr_irq_set: got %b expected 1", irq); end
    do_write(A_TCON, 32'h0000_0003);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL tmr_irq_clear: got %b expected 0", irq); end
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL tmr_tl_after: got %h expected fffffffd", rd); end
  endtask

  // Status clear written on the very cycle of a reload must not lose the interrupt
  task automatic test_status_race();
    logic [31:0] rd;
    do_write(A_TCON, 32'h0000_0000);
    do_write(A_TL, 32'hFFFF_FFFD);
    do_write(A_TCON, 32'h0000_0003);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL race_tl_pre: got %h expected ffffffff", rd); end
    do_write(A_TCON, 32'h0000_0003);
    do_read(A_TCON, rd);
    checks++; if (rd !== 32'h0000_0007) begin errors++; $display("[TB] FAIL race_tcon: got %h expected 00000007", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL race_irq: got %b expected 1", irq); end
    @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL race_irq_hold: got %b expected 1", irq); end
  endtask

  // TH write on the reload cycle: TL takes the old TH
  task automatic test_th_race();
    logic [31:0] rd;
    do_write(A_TCON, 32'h0000_0000);
    do_write(A_TL, 32'hFFFF_FFFD);
    do_write(A_TCON, 32'h0000_0001);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_write(A_TH, 32'h0000_0100);
    do_read(A_TL, rd);
    checks++; if (rd !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL th_race_tl: got %h expected fffffffc", rd); end
    do_read(A_TH, rd);
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("[TB] FAIL th_race_th: got %h expected 00000100", rd); end
    do_read(A_TCON, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("[TB] FAIL th_race_tcon: got %h expected 00000001", rd); end
  endtask

  // TL write while counting wins over the increment
  task automatic test_tl_write();
    logic [31:0] rd;
    do_write(A_TL, 32'h0000_0005);
    do_read(A_TL, rd);
    checks++; if (rd !== 32'h0000_0005) begin errors++; $display("[TB] FAIL tl_write: got %h expected 00000005", rd); end
    @(posedge clk);
    #1;
    do_read(A_TL, rd);
    checks++; if (rd !== 32'h0000_0006) begin errors++; $display("[TB] FAIL tl_count: got %h expected 00000006", rd); end
  endtask

  // Switch synchronizer latency, read-only switch, LED/digi widths, unmapped reads
  task automatic test_io();
    logic [31:0] rd;
    switch = 8'hA5;
    @(posedge clk);
    #1;
    do_read(A_SW, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL sw_one_cycle: got %h expected 00000000", rd); end
    @(posedge clk);
    #1;
    do_read(A_SW, rd);
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL sw_sync: got %h expected 000000a5", rd); end
    do_write(A_SW, 32'h0000_00FF);
    do_read(A_SW, rd);
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL sw_readonly: got %h expected 000000a5", rd); end
    do_write(A_LED, 32'h0000_01FF);
    checks++; if (led !== 8'hFF) begin errors++; $display("[TB] FAIL led_out: got %h expected ff", led); end
    do_read(A_LED, rd);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL led_read: got %h expected 000000ff", rd); end
    do_write(A_DIGI, 32'h000A_BCDE);
    checks++; if (digi !== 12'hCDE) begin errors++; $display("[TB] FAIL digi_out: got %h expected cde", digi); end
    do_read(A_DIGI, rd);
    checks++; if (rd !== 32'h0000_0CDE) begin errors++; $display("[TB] FAIL digi_read: got %h expected 00000cde", rd); end
    do_read(A_BAD, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd); end
`ifndef SYSTICK_EN
    do_read(A_SYS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL systick_absent: got %h expected 00000000", rd); end
`endif
  endtask

  // Asynchronous reset while counting with irq high
  task automatic test_reset_mid();
    logic [31:0] rd;
    do_write(A_TCON, 32'h0000_0000);
    do_write(A_TL, 32'hFFFF_FFFF);
    do_write(A_TCON, 32'h0000_0003);
    @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL mid_irq_pre: got %b expected 1", irq); end
    reset_b = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL mid_irq: got %b expected 0", irq); end
    checks++; if (led !== 8'h00) begin errors++; $display("[TB] FAIL mid_led: got %h expected 00", led); end
    checks++; if (digi !== 12'h000) begin errors++; $display("[TB] FAIL mid_digi: got %h expected 000", digi); end
    do_read(A_TL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_tl: got %h expected 00000000", rd); end
`ifdef SYSTICK_EN
    do_read(A_SYS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL systick_reset: got %h expected 00000000", rd); end
`endif
    @(negedge clk);
    reset_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL mid_irq_after: got %b expected 0", irq); end
    do_read(A_TL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_tl_after: got %h expected 00000000", rd); end
`ifdef SYSTICK_EN
    do_read(A_SYS, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("[TB] FAIL systick_count: got %h expected 00000005", rd); end
`endif
  endtask

  initial begin
    reset_b   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    switch    = '0;
    $display("[TB] starting data_mem_periph bench");
    test_reset();
    test_ram();
    test_timer_reload();
    test_status_race();
    test_th_race();
    test_tl_write();
    test_io();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
